// File: rtl/radix4_otf_converter.sv
// Digit-serial radix-4 on-the-fly converter: signed digits MSD first in, two's-complement word out.
// Optional illegal-digit (-4) detection is enabled by defining RADIX4_OTF_DIGIT_CHECK_EN.
module radix4_otf_converter #(
  parameter int no_of_digits = 8,
  parameter int radix_bits   = 3,
  parameter int radix        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [radix_bits-1:0]   din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*no_of_digits:0] dout,
  output logic                    digit_err
);

  localparam int W     = 2*no_of_digits + 1;
  localparam int LSB_W = $clog2(radix);
  localparam int CW    = (no_of_digits > 2) ? $clog2(no_of_digits) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(no_of_digits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [CW-1:0]      cnt_r;
  logic [W-1:0]       q_r;
  logic [W-1:0]       qm_r;
  logic [W-1:0]       dout_r;
  logic [W-1:0]       q_next_s;
  logic [W-1:0]       qm_next_s;
  logic [LSB_W-1:0]   d_m1_s;
  logic [LSB_W-1:0]   d_p3_s;
  logic               d_neg_s;
  logic               d_zero_s;
  logic               accept_s;
  logic               last_s;

  // Shift a word one radix-4 position left and append the new digit bits.
  function automatic logic [W-1:0] otf_shift(input logic [W-1:0] base,
                                             input logic [LSB_W-1:0] lsbs);
    return {base[W-1-LSB_W:0], lsbs};
  endfunction

  assign in_ready  = (state_r != DONE);
  assign out_valid = (state_r == DONE);
  assign dout      = dout_r;
  assign accept_s  = in_valid && in_ready;
  assign last_s    = (cnt_r == LAST_CNT);

  // OTF selection: negative digits borrow from QM so no carry ever ripples.
  always_comb begin
    d_neg_s   = din[radix_bits-1];
    d_zero_s  = (din == {radix_bits{1'b0}});
    d_m1_s    = din[LSB_W-1:0] - LSB_W'(1);
    d_p3_s    = din[LSB_W-1:0] + LSB_W'(3);
    q_next_s  = '0;
    qm_next_s = '0;
    if (!d_neg_s) begin
      q_next_s = otf_shift(q_r, din[LSB_W-1:0]);
    end else begin
      q_next_s = otf_shift(qm_r, din[LSB_W-1:0]);
    end
    if (!d_neg_s && !d_zero_s) begin
      qm_next_s = otf_shift(q_r, d_m1_s);
    end else begin
      qm_next_s = otf_shift(qm_r, d_p3_s);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_next_s = last_s ? DONE : ACC;
          end else begin
            state_next_s = IDLE;
          end
        end
        ACC: begin
          if (accept_s && last_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DONE;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Accumulators re-seed on completion so the next word always starts at Q=0, QM=-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      q_r    <= '0;
      qm_r   <= '1;
      dout_r <= '0;
    end else if (flush) begin
      cnt_r <= '0;
      q_r   <= '0;
      qm_r  <= '1;
    end else if (accept_s) begin
      if (last_s) begin
        cnt_r  <= '0;
        q_r    <= '0;
        qm_r   <= '1;
        dout_r <= q_next_s;
      end else begin
        cnt_r <= cnt_r + CW'(1);
        q_r   <= q_next_s;
        qm_r  <= qm_next_s;
      end
    end
  end

`ifdef RADIX4_OTF_DIGIT_CHECK_EN
  logic digit_err_r;
  assign digit_err = digit_err_r;

  // Sticky flag for the out-of-range digit -4; only reset or flush clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_err_r <= 1'b0;
    end else if (flush) begin
      digit_err_r <= 1'b0;
    end else if (accept_s && (din == {1'b1, {(radix_bits-1){1'b0}}})) begin
      digit_err_r <= 1'b1;
    end
  end
`else
  assign digit_err = 1'b0;
`endif

endmodule

// File: tb/tb_radix4_otf_converter.sv
// Bench for radix4_otf_converter: integer-sum reference model, per-cycle compare, literal pins.
module tb_radix4_otf_converter;
  localparam int N = 8;
  localparam int W = 2*N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   din = 3'd0;
  logic         in_ready;
  logic         out_valid;
  logic         digit_err;
  logic [W-1:0] dout;

  int total = 0;
  int bad = 0;

  int           m_cnt;
  int           m_sum;
  int           m_words;
  bit           m_pending;
  bit           m_err;
  logic [W-1:0] m_dout;
  int           wd[N];

  always #5 clk = ~clk;

  radix4_otf_converter #(.no_of_digits(N), .radix_bits(3), .radix(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .digit_err(digit_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sum = 0; m_pending = 0; m_err = 0; m_dout = '0;
  endtask

  // Reference: a word is just the integer sum d_k*4^(N-1-k), truncated to W bits.
  task automatic model_update();
    int d;
    d = $signed(din);
    if (flush) begin
      m_cnt = 0; m_sum = 0; m_pending = 0; m_err = 0;
    end else if (m_pending) begin
      if (out_ready) m_pending = 0;
    end else if (in_valid) begin
`ifdef RADIX4_OTF_DIGIT_CHECK_EN
      if (din == 3'b100) m_err = 1;
`endif
      m_sum = m_sum * 4 + d;
      m_cnt++;
      if (m_cnt == N) begin
        m_dout = m_sum[W-1:0];
        m_pending = 1;
        m_cnt = 0;
        m_sum = 0;
        m_words++;
      end
    end
  endtask

  // One clock: model follows the posedge, DUT outputs checked at the negedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("in_ready", in_ready, !m_pending);
    chk("out_valid", out_valid, m_pending);
    chk("dout", dout, m_dout);
    chk("digit_err", digit_err, m_err);
  endtask

  task automatic feed_word();
    int v;
    for (int k = 0; k < N; k++) begin
      v = wd[k];
      in_valid = 1'b1;
      din = v[2:0];
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int start;
    int r;
    logic exp_err;
`ifdef RADIX4_OTF_DIGIT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    m_words = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dout", dout, 17'h00000);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_digit_err", digit_err, 1'b0);
    rst_n = 1'b1;

    wd = '{3, 3, 3, 3, 3, 3, 3, 3};
    feed_word();
    chk("pos3_valid", out_valid, 1'b1);
    chk("pos3_dout", dout, 17'h0FFFF);
    step();

    wd = '{-3, -3, -3, -3, -3, -3, -3, -3};
    feed_word();
    chk("neg3_dout", dout, 17'h10001);
    step();

    wd = '{0, 0, 0, 0, 0, 0, 0, -1};
    feed_word();
    chk("lsd_m1_dout", dout, 17'h1FFFF);
    step();

    out_ready = 1'b0;
    wd = '{1, -1, 0, 0, 0, 0, 0, 0};
    feed_word();
    chk("p1m1_dout", dout, 17'h03000);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      din = 3'd3;
      step();
      chk("hold_dout", dout, 17'h03000);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold_release", out_valid, 1'b0);

    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; din = 3'd2; step();
    end
    flush = 1'b1; din = 3'd3; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_no_valid", out_valid, 1'b0);
    wd = '{1, 1, 1, 1, 1, 1, 1, 1};
    feed_word();
    chk("after_flush_dout", dout, 17'h05555);
    step();

    wd = '{1, 0, 0, 0, 0, 0, 0, -4};
    feed_word();
    chk("m4_dout", dout, 17'h03FFC);
    chk("m4_err", digit_err, exp_err);
    step();
    wd = '{1, 1, 1, 1, 1, 1, 1, 1};
    feed_word();
    chk("m4_err_sticky", digit_err, exp_err);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("m4_err_cleared", digit_err, 1'b0);

    start = m_words;
    cyc = 0;
    while (m_words < start + 1000 && cyc < 40000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 6)) - 3;
      din = r[2:0];
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 299) == 0);
      step();
      cyc++;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("random_budget", m_words - start, 1000);
    step();

    out_ready = 1'b0;
    wd = '{3, 3, 3, 3, 3, 3, 3, 3};
    feed_word();
    chk("pre_rst_dout", dout, 17'h0FFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_dout", dout, 17'h00000);
    chk("async_in_ready", in_ready, 1'b1);
    chk("async_digit_err", digit_err, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    wd = '{1, 1, 1, 1, 1, 1, 1, 1};
    feed_word();
    chk("post_rst_dout", dout, 17'h05555);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
